pipeline_exec_controller: RTL and testbench

Execution sequencer for the five-stage MIPS pipeline. It gates the clock-enable of all pipeline latches and the PC for free-run and single-step execution, and drains the pipeline when the decode stage reports a HALT instruction. On command it walks the register-file debug read port and streams every register plus the cycle counter to the debug transmitter through a valid/ready handshake.

---
 rtl/pipeline_exec_controller_pkg.sv | 21 ++
 rtl/pipeline_exec_controller_dump_sequencer.sv | 71 +++++++
 rtl/pipeline_exec_controller.sv | 155 +++++++++++++++
 tb/tb_pipeline_exec_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_exec_controller_pkg.sv
// Shared definitions for the pipeline execution sequencer: debug command codes,
// the HALT opcode and the sequencer state encoding.
package pipeline_exec_controller_pkg;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    // Opcode the ID stage decodes into its halt indication.
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4
    } state_e;

endpackage

// File: rtl/pipeline_exec_controller_dump_sequencer.sv
// Walks the register-file debug port and then emits the cycle counter,
// presenting one word at a time on a valid/ready stream.
module dump_sequencer
    import pipeline_exec_controller_pkg::*;
#(
    parameter int LEN      = 32,
    parameter int NB_ADDR  = 5,
    parameter int N_REGS   = 32,
    parameter int NB_CYCLE = 32
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                start,
    input  logic [NB_CYCLE-1:0] cycle_count,
    input  logic [LEN-1:0]      reg_rd_data,
    input  logic                dump_ready,
    output logic [NB_ADDR-1:0]  reg_rd_addr,
    output logic [LEN-1:0]      dump_data,
    output logic                dump_valid,
    output logic                done
);

    localparam logic [NB_ADDR:0] LAST_IDX = (NB_ADDR + 1)'(N_REGS);

    logic [NB_ADDR:0] idx_reg;
    logic             active_reg;
    logic [LEN-1:0]   cycle_word;
    logic             xfer;
    logic             at_last;

    generate
        if (NB_CYCLE >= LEN) begin : g_cycle_trunc
            assign cycle_word = cycle_count[LEN-1:0];
        end else begin : g_cycle_ext
            assign cycle_word = {{(LEN - NB_CYCLE){1'b0}}, cycle_count};
        end
    endgenerate

    assign xfer    = active_reg & dump_ready;
    assign at_last = (idx_reg == LAST_IDX);
    assign done    = xfer & at_last;

    always_ff @(posedge clk) begin
        if (srst) begin
            idx_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            idx_reg    <= '0;
            active_reg <= 1'b1;
        end else if (xfer) begin
            if (at_last) begin
                idx_reg    <= '0;
                active_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + (NB_ADDR + 1)'(1);
            end
        end
    end

    // Index only moves on a transfer, so address and data hold during stalls.
    assign dump_valid  = active_reg;
    assign reg_rd_addr = idx_reg[NB_ADDR-1:0];

    always_comb begin
        dump_data = '0;
        if (active_reg) begin
            dump_data = at_last ? cycle_word : reg_rd_data;
        end
    end

endmodule

// File: rtl/pipeline_exec_controller.sv
// Execution sequencer for the five-stage pipeline: free-run, single-step,
// post-HALT drain and register/cycle-count debug dump.
module pipeline_exec_controller
    import pipeline_exec_controller_pkg::*;
#(
    parameter int LEN      = 32,
    parameter int NB_ADDR  = 5,
    parameter int N_REGS   = 32,
    parameter int NB_CYCLE = 32,
    parameter int N_DRAIN  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic                i_halt,
    output logic                o_pipe_en,
    output logic                o_pc_en,
    output logic                o_ifid_flush,
    output logic [NB_ADDR-1:0]  o_reg_rd_addr,
    input  logic [LEN-1:0]      i_reg_rd_data,
    output logic [LEN-1:0]      o_dump_data,
    output logic                o_dump_valid,
    input  logic                i_dump_ready,
    output logic [NB_CYCLE-1:0] o_cycle_count,
    output logic                o_halted,
    output logic                o_done
);

    localparam int NB_DRAIN = $clog2(N_DRAIN + 1);

    state_e                state_reg;
    logic [NB_DRAIN-1:0]   drain_cnt_reg;
    logic [NB_CYCLE-1:0]   cycle_count_reg;
    logic                  halted_reg;
    logic                  done_reg;
    logic                  cmd_ready_reg;
    logic                  pipe_en_reg;
    logic                  pc_en_reg;
    logic                  ifid_flush_reg;
    logic                  dump_start;
    logic                  dump_done;

    assign dump_start = (state_reg == ST_IDLE) & i_cmd_valid & (i_cmd == CMD_DUMP);

    // Outputs are registered alongside the state so each is a pure function of it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= ST_IDLE;
            drain_cnt_reg   <= '0;
            cycle_count_reg <= '0;
            halted_reg      <= 1'b0;
            done_reg        <= 1'b0;
            cmd_ready_reg   <= 1'b1;
            pipe_en_reg     <= 1'b0;
            pc_en_reg       <= 1'b0;
            ifid_flush_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (pipe_en_reg) begin
                cycle_count_reg <= cycle_count_reg + NB_CYCLE'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        case (i_cmd)
                            CMD_RUN, CMD_STEP: begin
                                if (halted_reg) begin
                                    done_reg <= 1'b1;
                                end else begin
                                    state_reg     <= (i_cmd == CMD_RUN) ? ST_RUN : ST_STEP;
                                    cmd_ready_reg <= 1'b0;
                                    pipe_en_reg   <= 1'b1;
                                    pc_en_reg     <= 1'b1;
                                end
                            end
                            CMD_DUMP: begin
                                state_reg     <= ST_DUMP;
                                cmd_ready_reg <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (i_halt) begin
                        state_reg      <= ST_DRAIN;
                        halted_reg     <= 1'b1;
                        drain_cnt_reg  <= NB_DRAIN'(N_DRAIN);
                        pc_en_reg      <= 1'b0;
                        ifid_flush_reg <= 1'b1;
                    end else if (state_reg == ST_STEP) begin
                        state_reg     <= ST_IDLE;
                        done_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b1;
                        pipe_en_reg   <= 1'b0;
                        pc_en_reg     <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg - NB_DRAIN'(1);
                    if (drain_cnt_reg == NB_DRAIN'(1)) begin
                        state_reg      <= ST_IDLE;
                        done_reg       <= 1'b1;
                        cmd_ready_reg  <= 1'b1;
                        pipe_en_reg    <= 1'b0;
                        ifid_flush_reg <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (dump_done) begin
                        state_reg     <= ST_IDLE;
                        done_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    cmd_ready_reg  <= 1'b1;
                    pipe_en_reg    <= 1'b0;
                    pc_en_reg      <= 1'b0;
                    ifid_flush_reg <= 1'b0;
                end
            endcase
        end
    end

    dump_sequencer #(
        .LEN      (LEN),
        .NB_ADDR  (NB_ADDR),
        .N_REGS   (N_REGS),
        .NB_CYCLE (NB_CYCLE)
    ) u_dump_sequencer (
        .clk         (i_clk),
        .srst        (i_rst),
        .start       (dump_start),
        .cycle_count (cycle_count_reg),
        .reg_rd_data (i_reg_rd_data),
        .dump_ready  (i_dump_ready),
        .reg_rd_addr (o_reg_rd_addr),
        .dump_data   (o_dump_data),
        .dump_valid  (o_dump_valid),
        .done        (dump_done)
    );

    assign o_cmd_ready   = cmd_ready_reg;
    assign o_pipe_en     = pipe_en_reg;
    assign o_pc_en       = pc_en_reg;
    assign o_ifid_flush  = ifid_flush_reg;
    assign o_cycle_count = cycle_count_reg;
    assign o_halted      = halted_reg;
    assign o_done        = done_reg;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Randomized bench for the execution sequencer against a cycle-level model of
// the command, drain and dump rules, with a behavioural register file.
module tb_pipeline_exec_controller;
    import pipeline_exec_controller_pkg::*;

    localparam int LEN      = 32;
    localparam int NB_ADDR  = 5;
    localparam int N_REGS   = 32;
    localparam int NB_CYCLE = 32;
    localparam int N_DRAIN  = 3;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_cmd_valid = 1'b0;
    logic [1:0]          i_cmd = 2'b00;
    logic                i_halt = 1'b0;
    logic                i_dump_ready = 1'b0;
    logic                cmd_ready;
    logic                pipe_en;
    logic                pc_en;
    logic                ifid_flush;
    logic [NB_ADDR-1:0]  reg_rd_addr;
    logic [LEN-1:0]      reg_rd_data;
    logic [LEN-1:0]      dump_data;
    logic                dump_valid;
    logic [NB_CYCLE-1:0] cycle_count;
    logic                halted;
    logic                done;

    logic [LEN-1:0]      regs [N_REGS];
    logic [NB_CYCLE-1:0] exp_count = '0;
    logic                exp_halted = 1'b0;
    int                  checks = 0;
    int                  errors = 0;

    always #5 i_clk = ~i_clk;

    assign reg_rd_data = regs[reg_rd_addr];

    pipeline_exec_controller #(
        .LEN(LEN), .NB_ADDR(NB_ADDR), .N_REGS(N_REGS), .NB_CYCLE(NB_CYCLE), .N_DRAIN(N_DRAIN)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .o_cmd_ready   (cmd_ready),
        .i_halt        (i_halt),
        .o_pipe_en     (pipe_en),
        .o_pc_en       (pc_en),
        .o_ifid_flush  (ifid_flush),
        .o_reg_rd_addr (reg_rd_addr),
        .i_reg_rd_data (reg_rd_data),
        .o_dump_data   (dump_data),
        .o_dump_valid  (dump_valid),
        .i_dump_ready  (i_dump_ready),
        .o_cycle_count (cycle_count),
        .o_halted      (halted),
        .o_done        (done)
    );

    task automatic next_cycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) next_cycle();
        i_rst = 1'b0;
        exp_count  = '0;
        exp_halted = 1'b0;
        next_cycle();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({pipe_en, pc_en, ifid_flush} !== 3'b000) begin errors++; $display("FAIL reset_enables: got %b expected 000", {pipe_en, pc_en, ifid_flush}); end
        checks++; if (dump_valid !== 1'b0 || dump_data !== '0 || reg_rd_addr !== '0) begin errors++; $display("FAIL reset_dump: valid %b data %h addr %0d expected 0/0/0", dump_valid, dump_data, reg_rd_addr); end
        checks++; if (cycle_count !== '0 || halted !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status: count %0d halted %b done %b expected 0/0/0", cycle_count, halted, done); end
        $display("reset: outputs checked");
    endtask

    task automatic test_step(input int n);
        for (int i = 0; i < n; i++) begin
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL step_ready_before: got %b expected 1", cmd_ready); end
            i_cmd_valid = 1'b1; i_cmd = CMD_STEP;
            next_cycle();
            i_cmd_valid = 1'b0;
            checks++; if ({pipe_en, pc_en, ifid_flush, cmd_ready, done} !== 5'b11000) begin errors++; $display("FAIL step_active: got %b expected 11000", {pipe_en, pc_en, ifid_flush, cmd_ready, done}); end
            next_cycle();
            exp_count = exp_count + 1;
            checks++; if ({pipe_en, pc_en, cmd_ready, done} !== 4'b0011) begin errors++; $display("FAIL step_complete: got %b expected 0011", {pipe_en, pc_en, cmd_ready, done}); end
            checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL step_count: got %0d expected %0d", cycle_count, exp_count); end
            next_cycle();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL step_done_pulse: got %b expected 0", done); end
            $display("step %0d: cycle_count=%0d", i, cycle_count);
        end
    endtask

    task automatic test_run_halt();
        int n;
        n = $urandom_range(5, 20);
        i_cmd_valid = 1'b1; i_cmd = CMD_RUN;
        next_cycle();
        // Command stays asserted through RUN to exercise the held-request path.
        for (int e = 1; e <= n; e++) begin
            checks++; if ({pipe_en, pc_en, ifid_flush, cmd_ready, halted} !== 5'b11000) begin errors++; $display("FAIL run_active: edge %0d got %b expected 11000", e, {pipe_en, pc_en, ifid_flush, cmd_ready, halted}); end
            if (e == n) i_halt = 1'b1;
            next_cycle();
        end
        i_halt = 1'b0;
        exp_count  = exp_count + NB_CYCLE'(n);
        exp_halted = 1'b1;
        for (int d = 0; d < N_DRAIN; d++) begin
            checks++; if ({pipe_en, pc_en, ifid_flush, halted, cmd_ready, done} !== 6'b101100) begin errors++; $display("FAIL drain_state: cycle %0d got %b expected 101100", d, {pipe_en, pc_en, ifid_flush, halted, cmd_ready, done}); end
            next_cycle();
            exp_count = exp_count + 1;
        end
        checks++; if ({done, pipe_en, ifid_flush, cmd_ready, halted} !== 5'b10011) begin errors++; $display("FAIL run_complete: got %b expected 10011", {done, pipe_en, ifid_flush, cmd_ready, halted}); end
        checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL run_count: got %0d expected %0d", cycle_count, exp_count); end
        next_cycle();
        i_cmd_valid = 1'b0;
        checks++; if ({done, pipe_en, pc_en, cmd_ready} !== 4'b1001) begin errors++; $display("FAIL held_run_halted: got %b expected 1001", {done, pipe_en, pc_en, cmd_ready}); end
        checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL held_run_count: got %0d expected %0d", cycle_count, exp_count); end
        next_cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_pulse: got %b expected 0", done); end
        $display("run: halt after %0d edges, cycle_count=%0d", n, cycle_count);
    endtask

    task automatic test_step_halted();
        i_cmd_valid = 1'b1; i_cmd = CMD_STEP;
        next_cycle();
        i_cmd_valid = 1'b0;
        checks++; if ({done, pipe_en, pc_en, cmd_ready} !== 4'b1001) begin errors++; $display("FAIL step_halted: got %b expected 1001", {done, pipe_en, pc_en, cmd_ready}); end
        checks++; if (cycle_count !== exp_count) begin errors++; $display("FAIL step_halted_count: got %0d expected %0d", cycle_count, exp_count); end
        next_cycle();
        $display("step while halted: ignored");
    endtask

    task automatic test_dump(input int mode);
        int              idx;
        int              guard;
        logic            rdy;
        logic            tog;
        logic [LEN-1:0]  exp;
        for (int k = 0; k < N_REGS; k++) regs[k] = (mode != 0) ? $urandom : LEN'(k * 32'h11);
        i_cmd_valid = 1'b1; i_cmd = CMD_DUMP;
        next_cycle();
        i_cmd_valid = 1'b0;
        idx = 0; guard = 0; tog = 1'b1;
        while (idx <= N_REGS && guard < 400) begin
            exp = (idx < N_REGS) ? regs[idx] : exp_count;
            checks++; if (dump_valid !== 1'b1 || dump_data !== exp) begin errors++; $display("FAIL dump_word: idx %0d valid %b data %h expected 1/%h", idx, dump_valid, dump_data, exp); end
            if (idx < N_REGS) begin
                checks++; if (reg_rd_addr !== NB_ADDR'(idx)) begin errors++; $display("FAIL dump_addr: got %0d expected %0d", reg_rd_addr, idx); end
            end
            checks++; if ({pipe_en, cmd_ready, done, halted} !== {3'b000, exp_halted}) begin errors++; $display("FAIL dump_status: got %b expected %b", {pipe_en, cmd_ready, done, halted}, {3'b000, exp_halted}); end
            rdy = (mode != 0) ? 1'($urandom_range(0, 1)) : tog;
            tog = ~tog;
            i_dump_ready = rdy;
            i_halt = 1'($urandom_range(0, 1));
            next_cycle();
            if (rdy) idx++;
            guard++;
        end
        i_halt = 1'b0;
        i_dump_ready = 1'b0;
        checks++; if (guard >= 400) begin errors++; $display("FAIL dump_timeout: got %0d words expected %0d", idx, N_REGS + 1); end
        checks++; if ({dump_valid, done, cmd_ready} !== 3'b011 || dump_data !== '0) begin errors++; $display("FAIL dump_complete: valid/done/ready %b data %h expected 011/0", {dump_valid, done, cmd_ready}, dump_data); end
        next_cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dump_done_pulse: got %b expected 0", done); end
        $display("dump mode %0d: %0d words in %0d cycles", mode, idx, guard);
    endtask

    task automatic test_dump_reset();
        for (int k = 0; k < N_REGS; k++) regs[k] = $urandom;
        i_cmd_valid = 1'b1; i_cmd = CMD_DUMP;
        next_cycle();
        i_cmd_valid = 1'b0;
        i_dump_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            checks++; if (dump_valid !== 1'b1 || dump_data !== regs[w]) begin errors++; $display("FAIL abort_word: idx %0d valid %b data %h expected 1/%h", w, dump_valid, dump_data, regs[w]); end
            next_cycle();
        end
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        i_dump_ready = 1'b0;
        exp_count  = '0;
        exp_halted = 1'b0;
        checks++; if ({dump_valid, done, cmd_ready, halted} !== 4'b0010) begin errors++; $display("FAIL abort_status: got %b expected 0010", {dump_valid, done, cmd_ready, halted}); end
        checks++; if (reg_rd_addr !== '0 || dump_data !== '0 || cycle_count !== '0) begin errors++; $display("FAIL abort_values: addr %0d data %h count %0d expected 0", reg_rd_addr, dump_data, cycle_count); end
        next_cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done); end
        $display("dump aborted by reset at word 5");
    endtask

    task automatic test_step_halt();
        i_cmd_valid = 1'b1; i_cmd = CMD_STEP;
        next_cycle();
        i_cmd_valid = 1'b0;
        checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL step_halt_active: got %b expected 1", pipe_en); end
        i_halt = 1'b1;
        next_cycle();
        i_halt = 1'b0;
        exp_count  = exp_count + 1;
        exp_halted = 1'b1;
        for (int d = 0; d < N_DRAIN; d++) begin
            checks++; if ({pipe_en, pc_en, ifid_flush, halted, done} !== 5'b10110) begin errors++; $display("FAIL step_drain: cycle %0d got %b expected 10110", d, {pipe_en, pc_en, ifid_flush, halted, done}); end
            next_cycle();
            exp_count = exp_count + 1;
        end
        checks++; if ({done, pipe_en, cmd_ready} !== 3'b101 || cycle_count !== exp_count) begin errors++; $display("FAIL step_halt_complete: done/en/ready %b count %0d expected 101/%0d", {done, pipe_en, cmd_ready}, cycle_count, exp_count); end
        next_cycle();
        $display("step with halt: cycle_count=%0d", cycle_count);
    endtask

    initial begin
        for (int k = 0; k < N_REGS; k++) regs[k] = '0;
        test_reset();
        test_step(3);
        test_run_halt();
        test_step_halted();
        test_dump(0);
        test_dump_reset();
        test_dump(1);
        test_step_halt();
        test_dump(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
